// File: rtl/f16_conv_pkg.sv
// ---------------------------------------------------------------------------
// f16_conv_pkg
// Shared constants, types and the F32->F16 truncating conversion function
// used by f16_conv_scheduler.
// Contents:
//   F32_* / EXP_BIAS_DELTA  exponent thresholds of the conversion
//   F16_INF / F16_MIN_SUB   magnitude codes for saturation and the floor value
//   conv_flags_t            per-conversion event flags {sat, floor}
//   conv_result_t           conversion result word plus flags
//   out_state_t             output register occupancy (EMPTY / FULL)
//   f32_to_f16()            combinational conversion
// ---------------------------------------------------------------------------
package f16_conv_pkg;

    localparam logic [7:0]  F32_EXP_SAT      = 8'd142;
    localparam logic [7:0]  F32_EXP_NORM_MIN = 8'd113;
    localparam logic [7:0]  F32_EXP_SUB_MIN  = 8'd103;
    localparam logic [7:0]  EXP_BIAS_DELTA   = 8'd112;
    localparam logic [14:0] F16_INF          = 15'h7C00;
    localparam logic [14:0] F16_MIN_SUB      = 15'h0001;

    typedef struct packed {
        logic sat;
        logic floor;
    } conv_flags_t;

    typedef struct packed {
        logic [15:0] data;
        conv_flags_t flags;
    } conv_result_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Truncating conversion; no rounding anywhere.
    function automatic conv_result_t f32_to_f16(input logic [31:0] w);
        conv_result_t res;
        logic         s;
        logic [7:0]   e;
        logic [22:0]  m;
        logic [7:0]   e_adj;
        logic [7:0]   sh;
        logic [9:0]   sub_m;
        s     = w[31];
        e     = w[30:23];
        m     = w[22:0];
        e_adj = e - EXP_BIAS_DELTA;
        sh    = EXP_BIAS_DELTA - e;
        sub_m = 10'({1'b1, m[22:14]} >> sh[3:0]);
        res   = '0;
        if (e > F32_EXP_SAT) begin
            // Covers Inf and NaN as well: both collapse to signed Inf.
            res.data      = {s, F16_INF};
            res.flags.sat = 1'b1;
        end else if (e == 8'd0 && m == 23'd0) begin
            res.data = {s, 15'h0000};
        end else if (e >= F32_EXP_NORM_MIN) begin
            res.data = {s, e_adj[4:0], m[22:13]};
        end else if (e >= F32_EXP_SUB_MIN) begin
            // F16 subnormal: hidden bit made explicit, shifted by 0..9.
            res.data = {s, 5'h00, sub_m};
        end else begin
            // Too small for F16 but nonzero: keep the smallest magnitude so
            // the value never silently becomes zero.
            res.data        = {s, F16_MIN_SUB};
            res.flags.floor = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/f16_conv_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of i_req found
// searching upward from i_ptr, wrapping at N.
// Ports:
//   i_req        N      request vector
//   i_ptr        IW     search start index
//   o_grant      N      one-hot grant (all zero when no request)
//   o_grant_idx  IW     index of the granted bit (0 when none)
//   o_any        1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);

    int w_idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/f16_conv_scheduler.sv
// ---------------------------------------------------------------------------
// f16_conv_scheduler
// One F32->F16 conversion datapath shared by N_REQ requesters through a
// round-robin arbiter, feeding a single registered valid/ready output.
// Counts saturation and underflow-floor events for accuracy monitoring.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready is one-hot)
//   req_data                 packed F32 words, requester i at [32*i +: 32]
//   out_valid / out_ready    output handshake
//   out_data / out_id        F16 result and the requester that produced it
//   clr_cnt                  synchronous clear of both counters
//   sat_cnt / floor_cnt      saturating event counters
// ---------------------------------------------------------------------------
module f16_conv_scheduler
    import f16_conv_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int CNT_W = 16,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [IW-1:0]        out_id,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     sat_cnt,
    output logic [CNT_W-1:0]     floor_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    out_state_t       r_state;
    logic [15:0]      r_data;
    logic [IW-1:0]    r_id;
    logic [IW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_sat_cnt;
    logic [CNT_W-1:0] r_floor_cnt;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_any;
    logic             w_can_accept;
    logic             w_xfer;
    logic [IW-1:0]    w_ptr_next;
    logic [31:0]      w_word;
    conv_result_t     w_conv;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Draining and refilling in the same cycle keeps throughput at 1/clk.
    // Ready is held low during reset so a request is never consumed by a
    // cycle whose result is thrown away.
    assign w_can_accept = (r_state == ST_EMPTY) || (out_ready && r_state == ST_FULL);
    assign req_ready    = w_grant & {N_REQ{w_can_accept && !rst}};
    assign w_xfer       = w_any && w_can_accept && !rst;
    assign w_ptr_next   = (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + IW'(1);
    assign w_word       = req_data[32*w_grant_idx +: 32];
    assign w_conv       = f32_to_f16(w_word);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_data      <= '0;
            r_id        <= '0;
            r_ptr       <= '0;
            r_sat_cnt   <= '0;
            r_floor_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_state <= ST_FULL;
                r_data  <= w_conv.data;
                r_id    <= w_grant_idx;
                r_ptr   <= w_ptr_next;
            end else if (out_ready && r_state == ST_FULL) begin
                r_state <= ST_EMPTY;
            end

            // Clear wins over a same-cycle event.
            if (clr_cnt) begin
                r_sat_cnt <= '0;
            end else if (w_xfer && w_conv.flags.sat && r_sat_cnt != CNT_MAX) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end

            if (clr_cnt) begin
                r_floor_cnt <= '0;
            end else if (w_xfer && w_conv.flags.floor && r_floor_cnt != CNT_MAX) begin
                r_floor_cnt <= r_floor_cnt + 1'b1;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign sat_cnt   = r_sat_cnt;
    assign floor_cnt = r_floor_cnt;

endmodule

// File: tb/tb_f16_conv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_f16_conv_scheduler
// Self-checking bench for f16_conv_scheduler. Expected F16 results come from
// constant tables; a scoreboard queue receives {data, id} whenever a request
// handshake completes and is popped when the output handshake completes.
// A second instance with CNT_W=4 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_f16_conv_scheduler;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_id;
    logic         clr_cnt;
    logic [15:0]  sat_cnt;
    logic [15:0]  floor_cnt;

    logic [3:0]   d4_req_valid;
    logic [127:0] d4_req_data;
    logic [3:0]   d4_req_ready;
    logic         d4_out_valid;
    logic         d4_out_ready;
    logic [15:0]  d4_out_data;
    logic [1:0]   d4_out_id;
    logic         d4_clr_cnt;
    logic [3:0]   d4_sat_cnt;
    logic [3:0]   d4_floor_cnt;

    int           n_checks = 0;
    int           n_pass   = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [15:0]  exp_data [4];

    always #5 clk = ~clk;

    f16_conv_scheduler #(.N_REQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt),
        .floor_cnt (floor_cnt)
    );

    f16_conv_scheduler #(.N_REQ(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (d4_req_valid),
        .req_data  (d4_req_data),
        .req_ready (d4_req_ready),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .out_data  (d4_out_data),
        .out_id    (d4_out_id),
        .clr_cnt   (d4_clr_cnt),
        .sat_cnt   (d4_sat_cnt),
        .floor_cnt (d4_floor_cnt)
    );

    // Scoreboard monitor: pop on output handshake, push on request handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected got id=%0d data=%04h want no output", out_id, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_data !== mon_e.data || out_id !== mon_e.id)
                        $display("FAIL sb_out got id=%0d data=%04h want id=%0d data=%04h",
                                 out_id, out_data, mon_e.id, mon_e.data);
                    else
                        n_pass++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.data = exp_data[i];
                    mon_e.id   = 2'(i);
                    sb.push_back(mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word on one requester, confirm the grant, let it transfer.
    task automatic send(input int idx, input logic [31:0] w, input logic [15:0] e);
        logic [3:0] onehot;
        onehot                 = 4'(1 << idx);
        req_data[32*idx +: 32] = w;
        exp_data[idx]          = e;
        req_valid              = onehot;
        #1;
        n_checks++;
        if (req_ready !== onehot)
            $display("FAIL send_grant got %b want %b", req_ready, onehot);
        else
            n_pass++;
        tick();
        req_valid = 4'b0000;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        tick();
        tick();
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b want 0000", req_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 2'd0)
            $display("FAIL rst_out got v=%b d=%04h id=%0d want v=0 d=0000 id=0", out_valid, out_data, out_id);
        else n_pass++;
        n_checks++;
        if (sat_cnt !== 16'd0 || floor_cnt !== 16'd0)
            $display("FAIL rst_cnt got sat=%0d floor=%0d want 0 0", sat_cnt, floor_cnt);
        else n_pass++;
        req_valid = 4'b0000;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_basic_conv();
        logic [31:0] words [3];
        logic [15:0] exps  [3];
        words = '{32'h3F800000, 32'h38800000, 32'h38000000};
        exps  = '{16'h3C00, 16'h0400, 16'h0200};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(0, words[k], exps[k]);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exps[k] || out_id !== 2'd0)
                $display("FAIL basic_%0d got v=%b d=%04h id=%0d want v=1 d=%04h id=0",
                         k, out_valid, out_data, out_id, exps[k]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_special_values();
        logic [31:0] words [5];
        logic [15:0] exps  [5];
        words = '{32'h47800000, 32'h7FC00000, 32'h33800000, 32'h00000001, 32'h80000000};
        exps  = '{16'h7C00, 16'h7C00, 16'h0001, 16'h0001, 16'h8000};
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(k % 4, words[k], exps[k]);
            n_checks++;
            if (out_data !== exps[k] || out_id !== 2'(k % 4))
                $display("FAIL special_%0d got d=%04h id=%0d want d=%04h id=%0d",
                         k, out_data, out_id, exps[k], k % 4);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (sat_cnt !== 16'd2 || floor_cnt !== 16'd1)
            $display("FAIL special_cnt got sat=%0d floor=%0d want 2 1", sat_cnt, floor_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_data[32*i +: 32] = 32'h3F800000 + (32'(i) << 23);
        end
        exp_data  = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % 4))
                $display("FAIL rr_%0d got v=%b id=%0d want v=1 id=%0d", k, out_valid, out_id, k % 4);
            else n_pass++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure();
        req_valid = 4'b1111;
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_id !== 2'd2 || req_ready !== 4'b0000)
            $display("FAIL bp_start got id=%0d ready=%b want id=2 ready=0000", out_id, req_ready);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h4400 || out_id !== 2'd2 || req_ready !== 4'b0000)
                $display("FAIL bp_hold_%0d got v=%b d=%04h id=%0d ready=%b want v=1 d=4400 id=2 ready=0000",
                         k, out_valid, out_data, out_id, req_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) $display("FAIL bp_release got %b want 1000", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (out_id !== 2'd3 || out_data !== 16'h4800)
            $display("FAIL bp_next got id=%0d d=%04h want id=3 d=4800", out_id, out_data);
        else n_pass++;
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_counter_clear();
        send(0, 32'h7F800000, 16'h7C00);
        n_checks++;
        if (sat_cnt !== 16'd1) $display("FAIL clr_pre got %0d want 1", sat_cnt);
        else n_pass++;
        req_data[31:0] = 32'hFF800000;
        exp_data[0]    = 16'hFC00;
        req_valid      = 4'b0001;
        clr_cnt        = 1'b1;
        tick();
        clr_cnt   = 1'b0;
        req_valid = 4'b0000;
        n_checks++;
        if (sat_cnt !== 16'd0 || out_data !== 16'hFC00)
            $display("FAIL clr_same_cycle got sat=%0d d=%04h want 0 FC00", sat_cnt, out_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_counter_saturate();
        d4_req_data[31:0] = 32'h7F800000;
        d4_req_valid      = 4'b0001;
        #1;
        n_checks++;
        if (d4_req_ready !== 4'b0001) $display("FAIL sat4_ready got %b want 0001", d4_req_ready);
        else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) begin
                n_checks++;
                if (d4_sat_cnt !== 4'd14) $display("FAIL sat4_mid got %0d want 14", d4_sat_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (d4_sat_cnt !== 4'd15 || d4_floor_cnt !== 4'd0)
            $display("FAIL sat4_final got sat=%0d floor=%0d want 15 0", d4_sat_cnt, d4_floor_cnt);
        else n_pass++;
        n_checks++;
        if (d4_out_valid !== 1'b1 || d4_out_data !== 16'h7C00 || d4_out_id !== 2'd0)
            $display("FAIL sat4_out got v=%b d=%04h id=%0d want v=1 d=7C00 id=0",
                     d4_out_valid, d4_out_data, d4_out_id);
        else n_pass++;
        d4_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_while_full();
        out_ready = 1'b1;
        send(1, 32'h7F800000, 16'h7C00);
        tick();
        out_ready = 1'b0;
        send(2, 32'h3F800000, 16'h3C00);
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || sat_cnt !== 16'd1)
            $display("FAIL rwf_pre got v=%b id=%0d sat=%0d want v=1 id=2 sat=1", out_valid, out_id, sat_cnt);
        else n_pass++;
        req_valid = 4'b1010;
        rst       = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL rwf_ready_in_rst got %b want 0000", req_ready);
        else n_pass++;
        tick();
        sb.delete();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 2'd0 || sat_cnt !== 16'd0 || floor_cnt !== 16'd0)
            $display("FAIL rwf_after got v=%b d=%04h id=%0d sat=%0d floor=%0d want all 0",
                     out_valid, out_data, out_id, sat_cnt, floor_cnt);
        else n_pass++;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL rwf_first_grant got %b want 0010", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 16'h7C00)
            $display("FAIL rwf_first_out got v=%b id=%0d d=%04h want v=1 id=1 d=7C00", out_valid, out_id, out_data);
        else n_pass++;
        req_valid = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        out_ready    = 1'b1;
        clr_cnt      = 1'b0;
        d4_req_valid = '0;
        d4_req_data  = '0;
        d4_out_ready = 1'b1;
        d4_clr_cnt   = 1'b0;
        exp_data     = '{16'h0, 16'h0, 16'h0, 16'h0};
        test_reset();
        test_basic_conv();
        test_special_values();
        test_round_robin();
        test_back_pressure();
        test_counter_clear();
        test_counter_saturate();
        test_reset_while_full();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover got %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
